gpio_bus_master: RTL and testbench
==================================

// Module: gpio_bus_master
// PURPOSE
//  Bus initiator driving the GPIO register slave's bus_valid/bus_we/bus_addr/bus_wdata/bus_rdata port.
//  Takes commands (write, read, poll-until-match) on a valid/ready port and returns one response per command.
//  Sits between a host sequencer or test controller and the GPIO register block.
//  Slave contract: writes commit on the edge where bus_valid&bus_we; reads are combinational in the same cycle.
// PARAMETERS
//  POLL_GAP   4    idle cycles between poll attempts (0 = back-to-back attempts)
//  MAX_POLLS  16   poll attempts before timeout (used only with GPIO_MST_TIMEOUT_EN); must be >=1
// PORTS
//  clk         in   1   single clock; all logic on posedge
//  rst         in   1   synchronous, active-high reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   command accepted when cmd_valid&cmd_ready
//  cmd_op      in   2   00 WRITE, 01 READ, 10 POLL, 11 reserved
//  cmd_addr    in   32  target address (slave decodes [7:0])
//  cmd_wdata   in   32  write data (WRITE) / expected value (POLL)
//  cmd_mask    in   32  compare mask (POLL only)
//  rsp_valid   out  1   response present; held until rsp_ready
//  rsp_ready   in   1   response consumed when rsp_valid&rsp_ready
//  rsp_data    out  32  read data (READ), last sampled value (POLL), 0 (WRITE)
//  rsp_err     out  1   reserved opcode
//  rsp_timeout out  1   POLL exhausted MAX_POLLS attempts
//  bus_valid   out  1   bus access strobe, one cycle per access
//  bus_we      out  1   1 = write
//  bus_addr    out  32  access address
//  bus_wdata   out  32  write data
//  bus_rdata   in   32  slave read data, sampled in the bus_valid cycle
// BEHAVIOUR
//  Reset: FSM=IDLE; cmd_ready=0 during reset and 1 in the first IDLE cycle after it; all other outputs 0.
//  All bus_* and rsp_* outputs are registered.
//  FSM: IDLE -> BUS -> (GAP -> BUS)* -> RESP -> IDLE.
//  IDLE: cmd_ready=1; on accept latch op/addr/wdata/mask; clear attempt counter; next state BUS.
//  Reserved op: no bus access; go to RESP with rsp_err=1, rsp_data=0.
//  BUS: bus_valid=1 for exactly one cycle; bus_addr/bus_wdata from latched command.
//  BUS: bus_we=1 for WRITE and 0 for READ/POLL.
//  WRITE/READ: capture bus_rdata (READ) at end of BUS -> RESP; latency from accept edge to rsp_valid = 2 cycles.
//  POLL: match when (bus_rdata & mask) == (wdata & mask); mask=0 always matches on the first attempt.
//  POLL match -> RESP with rsp_data=bus_rdata.
//  POLL mismatch -> GAP for POLL_GAP cycles, then BUS again; POLL_GAP=0 goes BUS->BUS on consecutive cycles.
//  RESP: rsp_valid=1, outputs stable until rsp_ready; cmd_ready=0 until the cycle after the handshake.
//  Handshake to IDLE: rsp_* cleared; cmd_ready=1 the next cycle (back-to-back throughput = 1 cmd / 3 cycles).
//  bus_addr/bus_wdata hold last values outside BUS; bus_valid/bus_we are 0 outside BUS.
//  rst mid-operation: an in-flight access is abandoned and no response is issued; outputs return to reset values at that edge.
//  rst asserted in a BUS cycle: the write still reaches the slave in that cycle (the slave is out of this block's reset domain).
// CONFIGURATION
//  GPIO_MST_TIMEOUT_EN defined: attempt counter, width $clog2(MAX_POLLS+1).
//   After MAX_POLLS mismatches (no GAP after the last) -> RESP with rsp_timeout=1 and rsp_data = last sample.
//  GPIO_MST_TIMEOUT_EN undefined: POLL retries forever until match; rsp_timeout tied 0; no counter logic.
// STRUCTURE
//  Package gpio_bus_pkg: opcode constants (OP_WRITE/OP_READ/OP_POLL), FSM state encoding.
//  Package gpio_bus_pkg: register offsets GPIO_DATA 0x00, GPIO_DIR 0x04, GPIO_READ 0x08, shared with the slave.
//  One sub-module: gpio_poll_timer (GAP countdown + attempt counter, done/expired flags).
//  FSM, command latch and response registers live in the top module.
// TESTING (bench pairs the master with the GPIO register slave; gpio_in driven by the bench)
//  WRITE 0x04<-0x0000_00FF, then WRITE 0x00<-0x0000_00A5 -> gpio_out=0x0000_00A5; rsp_data=0 both; 2-cycle latency each.
//  READ 0x08 with dir=0x0000_00FF, gpio_in=0x1234_5600 -> rsp_data=0x1234_56A5, rsp_err=0.
//  POLL 0x08 mask=0x0000_0100 expect=0x0000_0100, gpio_in[8] raised after 20 cycles, POLL_GAP=4 -> match response.
//  Same POLL: rsp_data[8]=1, rsp_timeout=0, bus_valid pulses spaced 5 cycles apart.
//  With GPIO_MST_TIMEOUT_EN and MAX_POLLS=16, gpio_in[8] held 0 -> exactly 16 bus reads.
//  Same timeout case -> rsp_timeout=1, rsp_data[8]=0.
//  Op 11 -> no bus_valid, rsp_err=1.
//  rsp_ready held low 10 cycles -> rsp stable and cmd_ready=0 throughout.
//  rst pulsed mid-POLL -> no response issued; cmd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/gpio_bus_pkg.sv
// Shared definitions for the GPIO bus master: opcodes, FSM states and the
// register map it has in common with the GPIO register slave.
package gpio_bus_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [7:0] GPIO_DATA = 8'h00;
    localparam logic [7:0] GPIO_DIR  = 8'h04;
    localparam logic [7:0] GPIO_READ = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } gpio_mst_state_e;

    // Only bits selected by mask take part; an all-zero mask always matches.
    function automatic logic poll_match(input logic [31:0] sample,
                                        input logic [31:0] expect_v,
                                        input logic [31:0] mask);
        return ((sample ^ expect_v) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/gpio_poll_timer.sv
// Poll pacing for gpio_bus_master: GAP countdown plus, when GPIO_MST_TIMEOUT_EN
// is defined, an attempt counter that flags the final allowed poll attempt.
module gpio_poll_timer #(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic gap_load_i,
    input  logic gap_tick_i,
    input  logic att_clr_i,
    input  logic att_inc_i,
    output logic gap_done_o,
    output logic expired_o
);

    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;

    logic [GW-1:0] gap_q, gap_d;

    // Loaded on entry to GAP so the GAP state lasts exactly POLL_GAP cycles.
    always_comb begin
        gap_d = gap_q;
        if (gap_load_i) begin
            gap_d = GAP_LOAD;
        end else if (gap_tick_i && gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign gap_done_o = (gap_q == '0);

`ifdef GPIO_MST_TIMEOUT_EN
    localparam int unsigned AW = $clog2(MAX_POLLS + 1);

    logic [AW-1:0] att_q, att_d;

    always_comb begin
        att_d = att_q;
        if (att_clr_i) begin
            att_d = '0;
        end else if (att_inc_i && !expired_o) begin
            att_d = att_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            att_q <= '0;
        end else begin
            att_q <= att_d;
        end
    end

    // High while the attempt in progress is the last one allowed.
    assign expired_o = (att_q == AW'(MAX_POLLS - 1));
`else
    localparam int unsigned unused_max_polls = MAX_POLLS;
    logic unused_att;
    assign unused_att = att_clr_i ^ att_inc_i;
    assign expired_o  = 1'b0;
`endif

endmodule

// File: rtl/gpio_bus_master.sv
// Bus initiator for the GPIO register slave: WRITE / READ / POLL commands in,
// one response out per command. Define GPIO_MST_TIMEOUT_EN to bound POLL retries.
module gpio_bus_master
    import gpio_bus_pkg::*;
#(
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    gpio_mst_state_e state_q;
    logic [1:0]      op_q;
    logic [31:0]     mask_q;
    logic            cmd_ready_q;
    logic            rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [31:0]     rsp_data_q;
    logic            bus_valid_q, bus_we_q;
    logic [31:0]     bus_addr_q, bus_wdata_q;

    logic accept, is_poll_miss, match, gap_done, expired;

    assign accept       = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign match        = poll_match(bus_rdata, bus_wdata_q, mask_q);
    assign is_poll_miss = (state_q == ST_BUS) && (op_q == OP_POLL) && !match;

    gpio_poll_timer #(
        .POLL_GAP  (POLL_GAP),
        .MAX_POLLS (MAX_POLLS)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .gap_load_i (is_poll_miss && !expired),
        .gap_tick_i (state_q == ST_GAP),
        .att_clr_i  (accept),
        .att_inc_i  (is_poll_miss),
        .gap_done_o (gap_done),
        .expired_o  (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_WRITE;
            mask_q        <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        op_q        <= cmd_op;
                        mask_q      <= cmd_mask;
                        if (cmd_op == OP_RSVD) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q     <= ST_BUS;
                            bus_valid_q <= 1'b1;
                            bus_we_q    <= (cmd_op == OP_WRITE);
                            bus_addr_q  <= cmd_addr;
                            bus_wdata_q <= cmd_wdata;
                        end
                    end
                end
                ST_BUS: begin
                    bus_valid_q <= 1'b0;
                    bus_we_q    <= 1'b0;
                    if (op_q != OP_POLL) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= (op_q == OP_READ) ? bus_rdata : 32'd0;
                    end else if (match || expired) begin
                        state_q       <= ST_RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= bus_rdata;
                        rsp_timeout_q <= !match;
                    end else if (POLL_GAP == 0) begin
                        bus_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state_q     <= ST_BUS;
                        bus_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q       <= ST_IDLE;
                        cmd_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b0;
                        rsp_data_q    <= '0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign bus_valid   = bus_valid_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master paired with a behavioural GPIO register slave.
// Covers the timeout path only when GPIO_MST_TIMEOUT_EN is defined.
module tb_gpio_bus_master;
    import gpio_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_wdata, cmd_mask;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_data;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    logic [31:0] gpio_in;
    logic [31:0] slv_data = '0;
    logic [31:0] slv_dir  = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int bus_cnt = 0;
    int bus_times[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    gpio_bus_master dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata)
    );

    // GPIO register slave: writes commit on the strobe edge, reads are combinational.
    always @(posedge clk) begin
        if (bus_valid && bus_we) begin
            case (bus_addr[7:0])
                GPIO_DATA: slv_data <= bus_wdata;
                GPIO_DIR:  slv_dir  <= bus_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (bus_addr[7:0])
            GPIO_DATA: bus_rdata = slv_data;
            GPIO_DIR:  bus_rdata = slv_dir;
            GPIO_READ: bus_rdata = (slv_data & slv_dir) | (gpio_in & ~slv_dir);
            default:   bus_rdata = '0;
        endcase
    end

    always @(negedge clk) begin
        cyc++;
        if (bus_valid) begin
            bus_cnt++;
            bus_times.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference register model, derived from the slave's register rules.
    logic [31:0] mdl_data, mdl_dir;
    function automatic logic [31:0] model_read(input logic [31:0] addr);
        case (addr[7:0])
            8'h00:   return mdl_data;
            8'h04:   return mdl_dir;
            8'h08:   return (mdl_data & mdl_dir) | (gpio_in & ~mdl_dir);
            default: return 32'd0;
        endcase
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] mask);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_mask  = mask;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accepted", n < 50, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mask, input int hold,
                          output logic [31:0] data, output logic err, output logic tmo,
                          output int lat, output int nbus);
        int b0;
        int k;
        logic stable;
        b0 = bus_cnt;
        send_cmd(op, addr, wdata, mask);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 200);
        chk("rsp_arrives", rsp_valid, 1'b1);
        data = rsp_data;
        err  = rsp_err;
        tmo  = rsp_timeout;
        lat  = k;
        nbus = bus_cnt - b0;
        chk("bus_idle_in_resp", {bus_valid, bus_we}, 2'b00);
        if (nbus > 0) chk("bus_addr_held", bus_addr, addr);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== data || rsp_err !== err ||
                rsp_timeout !== tmo || cmd_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("rsp_stable_while_stalled", stable, 1'b1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("cmd_ready_after_handshake", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_nbus;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] d;
        logic e, t;
        int lat, nb, b1;
        logic ok;

        // Register state after vecs[0..1]: dir=0xFF, data=0xA5; gpio_in=0x1234_5600.
        vecs[0] = '{OP_WRITE, 32'h04, 32'h0000_00FF, 32'h0, 32'h0,         1'b0, 1};
        vecs[1] = '{OP_WRITE, 32'h00, 32'h0000_00A5, 32'h0, 32'h0,         1'b0, 1};
        vecs[2] = '{OP_READ,  32'h08, 32'h0,         32'h0, 32'h1234_56A5, 1'b0, 1};
        vecs[3] = '{OP_READ,  32'h00, 32'h0,         32'h0, 32'h0000_00A5, 1'b0, 1};
        vecs[4] = '{OP_READ,  32'h04, 32'h0,         32'h0, 32'h0000_00FF, 1'b0, 1};
        vecs[5] = '{OP_RSVD,  32'h00, 32'h0,         32'h0, 32'h0,         1'b1, 0};
        vecs[6] = '{OP_POLL,  32'h08, 32'hDEAD_BEEF, 32'h0, 32'h1234_56A5, 1'b0, 1};
        vecs[7] = '{OP_POLL,  32'h08, 32'h0000_00A5, 32'hFF, 32'h1234_56A5, 1'b0, 1};
        vecs[8] = '{OP_READ,  32'h0C, 32'h0,         32'h0, 32'h0,         1'b0, 1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_mask = '0; rsp_ready = 1'b0; gpio_in = 32'h1234_5600;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_flags", {rsp_valid, rsp_err, rsp_timeout, bus_valid, bus_we}, 5'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);

        foreach (vecs[i]) begin
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mask, 0, d, e, t, lat, nb);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            chk($sformatf("vec%0d_timeout", i), t, 1'b0);
            chk($sformatf("vec%0d_bus_accesses", i), nb, vecs[i].exp_nbus);
            if (vecs[i].op != OP_RSVD) chk($sformatf("vec%0d_latency", i), lat, 2);
            if (i == 1) chk("gpio_out_after_writes", slv_data, 32'h0000_00A5);
        end

        do_cmd(OP_READ, 32'h08, 32'h0, 32'h0, 10, d, e, t, lat, nb);
        chk("stalled_read_data", d, 32'h1234_56A5);

        // POLL that matches once gpio_in[8] rises 20 cycles after issue.
        bus_times.delete();
        fork
            begin
                repeat (20) @(negedge clk);
                gpio_in[8] = 1'b1;
            end
        join_none
        do_cmd(OP_POLL, 32'h08, 32'h0000_0100, 32'h0000_0100, 0, d, e, t, lat, nb);
        chk("poll_match_data", d, 32'h1234_57A5);
        chk("poll_match_flags", {e, t}, 2'b00);
        chk("poll_retried", nb >= 2, 1'b1);
        ok = (bus_times.size() == nb);
        for (int i = 1; i < bus_times.size(); i++)
            if (bus_times[i] - bus_times[i-1] != 5) ok = 1'b0;
        chk("poll_spacing_5", ok, 1'b1);

`ifdef GPIO_MST_TIMEOUT_EN
        gpio_in[8] = 1'b0;
        do_cmd(OP_POLL, 32'h08, 32'h0000_0100, 32'h0000_0100, 0, d, e, t, lat, nb);
        chk("timeout_bus_reads", nb, 16);
        chk("timeout_flag", t, 1'b1);
        chk("timeout_data", d, 32'h1234_56A5);
`endif

        // Reset in the middle of a POLL that can never match.
        gpio_in[8] = 1'b0;
        send_cmd(OP_POLL, 32'h08, 32'h0000_0100, 32'h0000_0100);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outputs", {rsp_valid, bus_valid, cmd_ready}, 3'b000);
        @(negedge clk);
        chk("midrst_cmd_ready_next", cmd_ready, 1'b1);
        b1 = bus_cnt;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b0;
        end
        chk("midrst_no_response", ok, 1'b1);
        chk("midrst_no_bus", bus_cnt - b1, 0);

        // Randomized commands against the register model.
        mdl_data = slv_data;
        mdl_dir  = slv_dir;
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [31:0] addr, wdata, mask, expd;
            int exp_nb;
            op = 2'($urandom_range(0, 3));
            gpio_in = $urandom;
            addr = 32'(4 * $urandom_range(0, 3));
            wdata = $urandom;
            mask = '0;
            exp_nb = 1;
            expd = '0;
            case (op)
                OP_WRITE: addr = ($urandom_range(0, 1) != 0) ? 32'h00 : 32'h04;
                OP_READ:  expd = model_read(addr);
                OP_POLL: begin
                    mask  = $urandom;
                    expd  = model_read(addr);
                    wdata = expd ^ ($urandom & ~mask);
                end
                default: exp_nb = 0;
            endcase
            exp_q.push_back(expd);
            do_cmd(op, addr, wdata, mask, $urandom_range(0, 3), d, e, t, lat, nb);
            chk("rand_data", d, exp_q.pop_front());
            chk("rand_err", e, op == OP_RSVD);
            chk("rand_bus_accesses", nb, exp_nb);
            if (op == OP_WRITE) begin
                if (addr == 32'h00) mdl_data = wdata;
                else mdl_dir = wdata;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
